// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and UART register map for the TX scheduler
package uart_pkg;
  typedef enum logic [2:0] {IDLE, WR_DATA, WR_CTRL, SETTLE, POLL, DONE} state_t;
  localparam logic [31:0] UART_CTRL_ADDR = 32'h0;
  localparam logic [31:0] UART_DATA_ADDR = 32'h4;
  localparam int CTRL_SEND_BIT = 0;
  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction
endpackage

// File: rtl/uart_tx_scheduler_if.sv
// uart_tx_scheduler_if: requester handshake plus UART register port of the TX scheduler
interface uart_tx_scheduler_if;
  logic [1:0]  req_i;
  logic [7:0]  data0_i;
  logic [7:0]  data1_i;
  logic [1:0]  ack_o;
  logic [1:0]  done_o;
  logic        timeout_o;
  logic        busy_o;
  logic        uart_we_o;
  logic [31:0] uart_addr_o;
  logic [31:0] uart_wdata_o;
  logic [31:0] uart_rdata_i;
  modport master (
    input  req_i, data0_i, data1_i, uart_rdata_i,
    output ack_o, done_o, timeout_o, busy_o, uart_we_o, uart_addr_o, uart_wdata_o
  );
  modport slave (
    output req_i, data0_i, data1_i, uart_rdata_i,
    input  ack_o, done_o, timeout_o, busy_o, uart_we_o, uart_addr_o, uart_wdata_o
  );
endinterface

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant, favouring the requester not served last
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant
);
  assign grant = &req ? ~last_grant : req[1];
endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: arbitrates two byte requesters onto a polled UART register port
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int POLL_TIMEOUT = 200000
) (
  input logic clk_i,
  input logic rst_n_i,
  uart_tx_scheduler_if.master bus
);
  localparam logic [17:0] POLL_LAST = 18'(POLL_TIMEOUT - 1);
  state_t      state, state_n;
  logic        gnt, take, grant_q, last_grant, poll_hit, sending;
  logic [7:0]  byte_q;
  logic [17:0] poll_cnt;
  logic [1:0]  ack_q, done_q;
  logic        timeout_q;
  logic        unused_rdata;
  assign unused_rdata = ^bus.uart_rdata_i[31:1];
  assign sending = bus.uart_rdata_i[CTRL_SEND_BIT];
  assign take = state == IDLE && |bus.req_i;
  rr_arbiter2 u_arb (
    .req       (bus.req_i),
    .last_grant(last_grant),
    .grant     (gnt)
  );
  always_comb begin
    state_n = state;
    poll_hit = 1'b0;
    case (state)
      IDLE:    state_n = take ? WR_DATA : IDLE;
      WR_DATA: state_n = WR_CTRL;
      WR_CTRL: state_n = SETTLE;
      SETTLE:  state_n = POLL;
      POLL: begin
        poll_hit = sending && poll_cnt == POLL_LAST;
        state_n = !sending ? DONE : poll_hit ? IDLE : POLL;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    bus.busy_o = state != IDLE;
    bus.uart_we_o = state == WR_DATA || state == WR_CTRL;
    bus.uart_addr_o = state == WR_DATA ? UART_DATA_ADDR : UART_CTRL_ADDR;
    bus.uart_wdata_o = state == WR_DATA ? {24'b0, byte_q} :
                       state == WR_CTRL ? 32'(1) << CTRL_SEND_BIT : '0;
    bus.ack_o = ack_q;
    bus.done_o = done_q;
    bus.timeout_o = timeout_q;
  end
  // pulses are registered so each lands in the cycle after the event that causes it
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
      grant_q <= 1'b0;
      last_grant <= 1'b1;
      byte_q <= '0;
      poll_cnt <= '0;
      ack_q <= '0;
      done_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state <= state_n;
      ack_q <= take ? onehot2(gnt) : 2'b00;
      done_q <= state == DONE ? onehot2(grant_q) : 2'b00;
      timeout_q <= poll_hit;
      poll_cnt <= state == POLL && state_n == POLL ? poll_cnt + 18'd1 : '0;
      if (take) begin
        grant_q <= gnt;
        byte_q <= gnt ? bus.data1_i : bus.data0_i;
      end
      if (state == DONE || poll_hit) last_grant <= grant_q;
    end
  end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: directed checks of arbitration, UART write sequence, polling and reset
module tb_uart_tx_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int vectors = 0;
  int errors = 0;
  int busy_len = 0;
  int busy_left;
  uart_tx_scheduler_if bus ();
  uart_tx_scheduler #(.POLL_TIMEOUT(16)) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bus    (bus)
  );
  always #5 clk = ~clk;
  // UART model: a ctrl write of send=1 keeps bit0 set for busy_len cycles
  assign bus.uart_rdata_i = {31'b0, busy_left != 0};
  always @(posedge clk or negedge rst_n)
    if (!rst_n) busy_left <= 0;
    else if (bus.uart_we_o && bus.uart_addr_o == 32'h0 && bus.uart_wdata_o[0]) busy_left <= busy_len;
    else if (busy_left > 0) busy_left <= busy_left - 1;
  always @(negedge clk)
    if (rst_n) begin
      vectors++;
      if ($countones({bus.ack_o, bus.done_o, bus.timeout_o}) > 1 ||
          (bus.uart_we_o && !((bus.uart_addr_o == 32'h4 && bus.busy_o) ||
                              (bus.uart_addr_o == 32'h0 && bus.uart_wdata_o == 32'h1)))) begin
        errors++;
        $display("FAIL monitor at %0t: ack=%b done=%b timeout=%b we=%b addr=%h wdata=%h, required at most one pulse bit and we only on data/ctrl writes",
                 $time, bus.ack_o, bus.done_o, bus.timeout_o, bus.uart_we_o, bus.uart_addr_o, bus.uart_wdata_o);
      end
    end
  task automatic apply_reset;
    rst_n = 1'b0;
    bus.req_i = 2'b00;
    bus.data0_i = 8'h00;
    bus.data1_i = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic wait_ack(output int n, output logic [1:0] a);
    n = 0;
    a = 2'b00;
    while (n < 40 && a == 2'b00) begin
      @(negedge clk);
      n++;
      a = bus.ack_o;
    end
  endtask
  task automatic wait_done(output int n, output logic [1:0] d, output logic t);
    n = 0;
    d = 2'b00;
    t = 1'b0;
    while (n < 60 && d == 2'b00 && !t) begin
      @(negedge clk);
      n++;
      d = bus.done_o;
      t = bus.timeout_o;
    end
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    bus.req_i = 2'b11;
    bus.data0_i = 8'hFF;
    bus.data1_i = 8'hFF;
    busy_len = 0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({bus.ack_o, bus.done_o, bus.timeout_o, bus.busy_o, bus.uart_we_o} !== 7'b0 ||
        bus.uart_addr_o !== 32'h0 || bus.uart_wdata_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: ack=%b done=%b timeout=%b busy=%b we=%b addr=%h wdata=%h, required all zero",
               bus.ack_o, bus.done_o, bus.timeout_o, bus.busy_o, bus.uart_we_o, bus.uart_addr_o, bus.uart_wdata_o);
    end
    bus.req_i = 2'b00;
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_single;
    int n;
    logic [1:0] a, d;
    logic t;
    apply_reset;
    busy_len = 3;
    bus.req_i = 2'b01;
    bus.data0_i = 8'h7B;
    bus.data1_i = 8'h99;
    wait_ack(n, a);
    vectors++;
    if (n !== 1 || a !== 2'b01) begin
      errors++;
      $display("FAIL single_ack: got ack=%b after %0d cycles, required 01 after 1", a, n);
    end
    vectors++;
    if (bus.uart_we_o !== 1'b1 || bus.uart_addr_o !== 32'h4 || bus.uart_wdata_o !== 32'h7B) begin
      errors++;
      $display("FAIL single_wr_data: we=%b addr=%h wdata=%h, required 1/00000004/0000007b",
               bus.uart_we_o, bus.uart_addr_o, bus.uart_wdata_o);
    end
    bus.req_i = 2'b00;
    @(negedge clk);
    vectors++;
    if (bus.uart_we_o !== 1'b1 || bus.uart_addr_o !== 32'h0 || bus.uart_wdata_o !== 32'h1) begin
      errors++;
      $display("FAIL single_wr_ctrl: we=%b addr=%h wdata=%h, required 1/00000000/00000001",
               bus.uart_we_o, bus.uart_addr_o, bus.uart_wdata_o);
    end
    @(negedge clk);
    vectors++;
    if (bus.uart_we_o !== 1'b0 || bus.uart_addr_o !== 32'h0 || bus.busy_o !== 1'b1) begin
      errors++;
      $display("FAIL single_settle: we=%b addr=%h busy=%b, required 0/00000000/1",
               bus.uart_we_o, bus.uart_addr_o, bus.busy_o);
    end
    // three busy polls after settle, so done is 7 cycles after ack (5 after settle)
    wait_done(n, d, t);
    vectors++;
    if (n !== 5 || d !== 2'b01 || t !== 1'b0) begin
      errors++;
      $display("FAIL single_done: done=%b timeout=%b after %0d cycles, required done=01 timeout=0 after 5", d, t, n);
    end
    vectors++;
    if (bus.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: busy=%b, required 0", bus.busy_o);
    end
  endtask
  task automatic test_min_latency;
    int n;
    logic [1:0] a, d;
    logic t;
    apply_reset;
    busy_len = 0;
    bus.req_i = 2'b01;
    bus.data0_i = 8'h5A;
    wait_ack(n, a);
    bus.req_i = 2'b00;
    wait_done(n, d, t);
    vectors++;
    if (n !== 5 || d !== 2'b01 || t !== 1'b0) begin
      errors++;
      $display("FAIL min_latency: done=%b timeout=%b %0d cycles after ack, required done=01 after 5", d, t, n);
    end
  endtask
  task automatic test_round_robin;
    int n;
    logic [1:0] a, d;
    logic t;
    logic [1:0] exp_g [3] = '{2'b01, 2'b10, 2'b01};
    logic [31:0] exp_w [3] = '{32'hA5, 32'h3C, 32'hA5};
    apply_reset;
    busy_len = 1;
    bus.req_i = 2'b11;
    bus.data0_i = 8'hA5;
    bus.data1_i = 8'h3C;
    for (int i = 0; i < 3; i++) begin
      wait_ack(n, a);
      vectors++;
      if (a !== exp_g[i] || bus.uart_wdata_o !== exp_w[i]) begin
        errors++;
        $display("FAIL rr_grant[%0d]: ack=%b wdata=%h, required ack=%b wdata=%h", i, a, bus.uart_wdata_o, exp_g[i], exp_w[i]);
      end
      wait_done(n, d, t);
      vectors++;
      if (d !== exp_g[i] || t !== 1'b0) begin
        errors++;
        $display("FAIL rr_done[%0d]: done=%b timeout=%b, required done=%b timeout=0", i, d, t, exp_g[i]);
      end
    end
    bus.req_i = 2'b00;
  endtask
  task automatic test_timeout;
    int n;
    logic [1:0] a, d;
    logic t;
    apply_reset;
    busy_len = 100000;
    bus.req_i = 2'b10;
    bus.data1_i = 8'hE1;
    wait_ack(n, a);
    bus.req_i = 2'b00;
    vectors++;
    if (a !== 2'b10) begin
      errors++;
      $display("FAIL timeout_ack: ack=%b, required 10", a);
    end
    // ack(WR_DATA), WR_CTRL, SETTLE, 16 POLL cycles, then the pulse: 19 cycles
    wait_done(n, d, t);
    vectors++;
    if (n !== 19 || t !== 1'b1 || d !== 2'b00) begin
      errors++;
      $display("FAIL timeout_pulse: timeout=%b done=%b after %0d cycles, required timeout=1 done=00 after 19", t, d, n);
    end
    vectors++;
    if (bus.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL timeout_idle: busy=%b, required 0", bus.busy_o);
    end
    @(negedge clk);
    vectors++;
    if (bus.timeout_o !== 1'b0 || bus.done_o !== 2'b00) begin
      errors++;
      $display("FAIL timeout_single_pulse: timeout=%b done=%b, required 0/00", bus.timeout_o, bus.done_o);
    end
    busy_len = 0;
    bus.req_i = 2'b11;
    bus.data0_i = 8'h42;
    wait_ack(n, a);
    bus.req_i = 2'b00;
    vectors++;
    if (a !== 2'b01 || bus.uart_wdata_o !== 32'h42) begin
      errors++;
      $display("FAIL timeout_next_grant: ack=%b wdata=%h, required 01/00000042", a, bus.uart_wdata_o);
    end
    wait_done(n, d, t);
    vectors++;
    if (d !== 2'b01 || t !== 1'b0) begin
      errors++;
      $display("FAIL timeout_next_done: done=%b timeout=%b, required 01/0", d, t);
    end
  endtask
  task automatic test_reset_mid;
    int n;
    logic [1:0] a, d, seen;
    logic t;
    apply_reset;
    busy_len = 100;
    bus.req_i = 2'b01;
    bus.data0_i = 8'h11;
    wait_ack(n, a);
    bus.req_i = 2'b00;
    repeat (5) @(negedge clk);
    vectors++;
    if (bus.busy_o !== 1'b1 || bus.uart_we_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_polling: busy=%b we=%b, required 1/0", bus.busy_o, bus.uart_we_o);
    end
    #3 rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.ack_o, bus.done_o, bus.timeout_o, bus.busy_o, bus.uart_we_o} !== 7'b0 ||
        bus.uart_addr_o !== 32'h0 || bus.uart_wdata_o !== 32'h0) begin
      errors++;
      $display("FAIL mid_async_reset: ack=%b done=%b timeout=%b busy=%b we=%b addr=%h wdata=%h, required all zero",
               bus.ack_o, bus.done_o, bus.timeout_o, bus.busy_o, bus.uart_we_o, bus.uart_addr_o, bus.uart_wdata_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 2'b00;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      seen = seen | bus.ack_o | bus.done_o | {1'b0, bus.timeout_o};
    end
    vectors++;
    if (seen !== 2'b00) begin
      errors++;
      $display("FAIL mid_no_pulse: pulses seen=%b, required 00", seen);
    end
    busy_len = 0;
    bus.req_i = 2'b11;
    bus.data0_i = 8'h21;
    bus.data1_i = 8'h22;
    wait_ack(n, a);
    bus.req_i = 2'b00;
    vectors++;
    if (a !== 2'b01) begin
      errors++;
      $display("FAIL mid_regrant: ack=%b, required 01", a);
    end
    wait_done(n, d, t);
  endtask
  task automatic test_drop;
    int n;
    logic [1:0] a, d;
    logic t;
    apply_reset;
    busy_len = 2;
    bus.req_i = 2'b10;
    bus.data1_i = 8'hC3;
    wait_ack(n, a);
    vectors++;
    if (a !== 2'b10 || bus.uart_wdata_o !== 32'hC3) begin
      errors++;
      $display("FAIL drop_ack: ack=%b wdata=%h, required 10/000000c3", a, bus.uart_wdata_o);
    end
    @(negedge clk);
    bus.req_i = 2'b00;
    wait_done(n, d, t);
    vectors++;
    if (d !== 2'b10 || t !== 1'b0) begin
      errors++;
      $display("FAIL drop_done: done=%b timeout=%b, required 10/0", d, t);
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset;
    test_single;
    test_min_latency;
    test_round_robin;
    test_timeout;
    test_reset_mid;
    test_drop;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
